game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level sequencer for the whack-a-mole game. It owns the game state machine and decides when the countdown timer is held in reset and when it is released to count. It gates mole activity and accumulates the current score and a session high score. It sits between the debounced push-button, the timer block (driving its `rst`/`is_started` and reading back `time_left`) and the mole/hit logic.

## Interface
- `READY_SECS`, default 3: length of the pre-game "get ready" countdown, in seconds (1..3).
- `SCORE_W`, default 8: width of `score` and `high_score`.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_btn`  in  1: debounced start button level, synchronous to `clk`; only its rising edge is used.
- `sec_tick`  in  1: one-`clk`-cycle pulse once per second.
- `time_left`  in  6: seconds remaining, from the timer block.
- `hit`  in  1: one-cycle pulse per successful whack.
- `timer_rst`  out  1: drives the timer block's `rst`.
- `is_started`  out  1: drives the timer block's `is_started`.
- `mole_en`  out  1: enables mole generation.
- `game_over`  out  1: high while in OVER.
- `state`  out  2: IDLE=0, READY=1, PLAY=2, OVER=3.
- `ready_cnt`  out  2: remaining get-ready seconds, for display.
- `score`  out  SCORE_W: current game score.
- `high_score`  out  SCORE_W: best score since reset.

## Operation
- Start edge: `start_rise = start_btn & ~start_d`. `start_d` is a register of `start_btn`.
- IDLE:
  - `timer_rst`=1; `is_started`=0; `mole_en`=0.
  - On `start_rise`: go to READY, load `ready_cnt`=READY_SECS, clear `score` to 0.
- READY:
  - `timer_rst`=1, so the timer is held at its full game time.
  - On `sec_tick`: if `ready_cnt`==1, go to PLAY with `ready_cnt`=0; otherwise decrement `ready_cnt`.
  - `start_rise` is ignored.
- PLAY:
  - `timer_rst`=0; `is_started`=1; `mole_en`=1.
  - On `hit`: `score` += 1, saturating at 2^SCORE_W−1.
  - When `time_left`==0 is sampled: go to OVER.
  - A `hit` in that same cycle is still counted.
  - `start_rise` is ignored.
- OVER:
  - `game_over`=1; `is_started`=0; `mole_en`=0; `timer_rst`=0, so the display holds 00.
  - `hit` is ignored; `score` is frozen.
  - On the first OVER cycle, `high_score` ← `score` if `score` > `high_score`, using a strict compare.
  - On `start_rise`: go to IDLE. A second press is needed to begin a new game.
- Output decoding:
  - `timer_rst`, `is_started`, `mole_en` and `game_over` are decoded combinationally from the registered state only.
  - They have no input-to-output combinational path.
- Reset, all synchronous: `state`=IDLE, `score`=0, `high_score`=0, `ready_cnt`=0, `start_d`=0.
  - Outputs after reset: `timer_rst`=1, others 0.
- `rst` in any state, including mid-PLAY, abandons the game and also clears `high_score`.

## Timing
- State transitions take effect on the `clk` edge after the qualifying input is sampled. Each transition costs 1 cycle of latency.
- `score` and `high_score` are registered. `score` updates 1 cycle after `hit`.
- `high_score` is valid 2 cycles after the `time_left`==0 sample:
  - 1 cycle to enter OVER;
  - 1 cycle for the compare.
- `start_btn` held high across several cycles yields exactly one `start_rise`.
- PLAY entry: `time_left` is already at full game time because the timer was held in reset throughout READY, so PLAY cannot end spuriously on entry.
- A `sec_tick` that coincides with the READY→PLAY transition is consumed by READY; the timer's first decrement is on a later tick.

## Test plan
- Reset then idle:
  - Assert `rst` 2 cycles.
  - Expect `state`=0, `timer_rst`=1, `score`=0, `high_score`=0, `is_started`=0.
  - Toggle `hit` 5× → `score` stays 0.
- Ready countdown:
  - One `start_rise` → `state`=1, `ready_cnt`=3.
  - Ticks 1, 2, 3 → `ready_cnt` 2, 1, then `state`=2 with `ready_cnt`=0 and `is_started`=1.
- Scoring and end:
  - In PLAY, 7 `hit` pulses → `score`=7.
  - Drive `time_left`=0 with a coincident `hit` → `score`=8, `state`=3, `game_over`=1.
  - `high_score`=8 one cycle later.
- High-score compare:
  - Second game scoring 5 → `high_score` stays 8.
  - Third game scoring 9 → `high_score`=9.
- Saturation:
  - With SCORE_W=8, 260 hits → `score`=255.
- Edge and reset cases:
  - Hold `start_btn` high 10 cycles in IDLE → exactly one IDLE→READY transition.
  - `start_rise` in PLAY → no state change.
  - `rst` mid-PLAY → IDLE, `score`=0, `high_score`=0 next cycle.

Source files
------------

// File: rtl/game_ctrl.sv
// Whack-a-mole game sequencer: owns the game FSM, holds/releases the countdown
// timer, gates mole activity and tracks the current and session-best score.
module game_ctrl #(
   parameter int unsigned READY_SECS = 3,
   parameter int unsigned SCORE_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               sec_tick,
   input  logic [5:0]         time_left,
   input  logic               hit,
   output logic               timer_rst,
   output logic               is_started,
   output logic               mole_en,
   output logic               game_over,
   output logic [1:0]         state,
   output logic [1:0]         ready_cnt,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t state_q;
   logic   start_d;
   logic   start_rise;
   logic   over_first;

   assign start_rise = start_btn & ~start_d;

   // Game FSM with score and high-score bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         start_d    <= 1'b0;
         over_first <= 1'b0;
         ready_cnt  <= '0;
         score      <= '0;
         high_score <= '0;
      end else begin
         start_d    <= start_btn;
         over_first <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_rise) begin
                  state_q   <= READY;
                  ready_cnt <= 2'(READY_SECS);
                  score     <= '0;
               end
            end
            READY: begin
               if (sec_tick) begin
                  if (ready_cnt == 2'd1) begin
                     state_q   <= PLAY;
                     ready_cnt <= '0;
                  end else begin
                     ready_cnt <= ready_cnt - 2'd1;
                  end
               end
            end
            PLAY: begin
               if (hit && (score != SCORE_MAX)) begin
                  score <= score + SCORE_W'(1);
               end
               if (time_left == 6'd0) begin
                  state_q    <= OVER;
                  over_first <= 1'b1;
               end
            end
            OVER: begin
               // Score is frozen here, so one compare on entry is enough.
               if (over_first && (score > high_score)) begin
                  high_score <= score;
               end
               if (start_rise) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Control outputs depend on the registered state only.
   assign timer_rst  = (state_q == IDLE) || (state_q == READY);
   assign is_started = (state_q == PLAY);
   assign mole_en    = (state_q == PLAY);
   assign game_over  = (state_q == OVER);
   assign state      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed scoreboard bench for game_ctrl: expectations are queued as stimulus
// is applied and drained against the DUT outputs after each clock edge.
module tb_game_ctrl;

   localparam int unsigned SCORE_W = 8;
   localparam int unsigned SMAX    = 255;

   localparam int SIG_STATE = 0;
   localparam int SIG_RCNT  = 1;
   localparam int SIG_SCORE = 2;
   localparam int SIG_HIGH  = 3;
   localparam int SIG_TRST  = 4;
   localparam int SIG_START = 5;
   localparam int SIG_MOLE  = 6;
   localparam int SIG_OVER  = 7;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start_btn = 1'b0;
   logic               sec_tick = 1'b0;
   logic [5:0]         time_left = 6'd40;
   logic               hit = 1'b0;
   logic               timer_rst;
   logic               is_started;
   logic               mole_en;
   logic               game_over;
   logic [1:0]         state;
   logic [1:0]         ready_cnt;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] high_score;

   typedef struct {
      string       tag;
      int          sig;
      int unsigned val;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned model_high = 0;

   game_ctrl #(.READY_SECS(3), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .sec_tick(sec_tick),
      .time_left(time_left), .hit(hit), .timer_rst(timer_rst),
      .is_started(is_started), .mole_en(mole_en), .game_over(game_over),
      .state(state), .ready_cnt(ready_cnt), .score(score),
      .high_score(high_score)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input string tag, input int sig, input int unsigned val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endfunction

   function automatic logic [31:0] observe(input int sig);
      case (sig)
         SIG_STATE: return 32'(state);
         SIG_RCNT:  return 32'(ready_cnt);
         SIG_SCORE: return 32'(score);
         SIG_HIGH:  return 32'(high_score);
         SIG_TRST:  return 32'(timer_rst);
         SIG_START: return 32'(is_started);
         SIG_MOLE:  return 32'(mole_en);
         SIG_OVER:  return 32'(game_over);
         default:   return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sig);
         n_tests++;
         assert (obs === 32'(e.val)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   // One complete game: start, ready countdown, n_hits hits, time-out, back to IDLE.
   task automatic play_game(input int n_hits);
      int unsigned exp_score;
      exp_score = (n_hits > int'(SMAX)) ? SMAX : 32'(n_hits);
      start_btn = 1'b1; tick(); start_btn = 1'b0;
      push("g_ready_state", SIG_STATE, 1); push("g_ready_cnt", SIG_RCNT, 3);
      push("g_score_clr", SIG_SCORE, 0);
      drain();
      for (int i = 0; i < 3; i++) begin
         sec_tick = 1'b1; tick(); sec_tick = 1'b0;
         push("g_cnt", SIG_RCNT, 32'(2 - i));
         push("g_cnt_state", SIG_STATE, (i == 2) ? 2 : 1);
         drain();
      end
      for (int i = 0; i < n_hits; i++) begin
         hit = 1'b1; tick(); hit = 1'b0; tick();
      end
      push("g_score", SIG_SCORE, exp_score);
      drain();
      time_left = 6'd0; tick();
      push("g_over_state", SIG_STATE, 3); push("g_over_flag", SIG_OVER, 1);
      drain();
      tick();
      if (exp_score > model_high) model_high = exp_score;
      push("g_high", SIG_HIGH, model_high);
      drain();
      time_left = 6'd40;
      start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
      push("g_back_idle", SIG_STATE, 0);
      drain();
   endtask

   initial begin
      // Reset and idle defaults
      rst = 1'b1; tick(); tick();
      push("rst_state", SIG_STATE, 0); push("rst_trst", SIG_TRST, 1);
      push("rst_score", SIG_SCORE, 0); push("rst_high", SIG_HIGH, 0);
      push("rst_started", SIG_START, 0); push("rst_mole", SIG_MOLE, 0);
      push("rst_over", SIG_OVER, 0); push("rst_rcnt", SIG_RCNT, 0);
      drain();
      rst = 1'b0; tick();
      for (int i = 0; i < 5; i++) begin
         hit = 1'b1; tick(); hit = 1'b0; tick();
      end
      push("idle_hit_score", SIG_SCORE, 0); push("idle_state", SIG_STATE, 0);
      drain();

      // Held start button: one transition into READY only
      start_btn = 1'b1; tick();
      push("start_state", SIG_STATE, 1); push("start_rcnt", SIG_RCNT, 3);
      push("ready_trst", SIG_TRST, 1); push("ready_started", SIG_START, 0);
      drain();
      for (int i = 0; i < 9; i++) begin
         tick();
         push("hold_state", SIG_STATE, 1); push("hold_rcnt", SIG_RCNT, 3);
         drain();
      end
      start_btn = 1'b0; tick();

      // Ready countdown
      for (int i = 0; i < 3; i++) begin
         sec_tick = 1'b1; tick(); sec_tick = 1'b0;
         push("cnt_rcnt", SIG_RCNT, 32'(2 - i));
         push("cnt_state", SIG_STATE, (i == 2) ? 2 : 1);
         drain();
         tick();
      end
      push("play_started", SIG_START, 1); push("play_mole", SIG_MOLE, 1);
      push("play_trst", SIG_TRST, 0);
      drain();

      // Scoring
      for (int i = 1; i <= 7; i++) begin
         hit = 1'b1; tick(); hit = 1'b0;
         push("hit_score", SIG_SCORE, 32'(i));
         drain();
         tick();
      end

      // Start press during PLAY is ignored
      start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
      push("play_start_ign", SIG_STATE, 2);
      drain();

      // Time-out with a coincident hit
      time_left = 6'd0; hit = 1'b1; tick(); hit = 1'b0;
      push("end_score", SIG_SCORE, 8); push("end_state", SIG_STATE, 3);
      push("end_over", SIG_OVER, 1); push("end_started", SIG_START, 0);
      push("end_mole", SIG_MOLE, 0); push("end_trst", SIG_TRST, 0);
      push("end_high_pre", SIG_HIGH, 0);
      drain();
      tick();
      model_high = 8;
      push("end_high", SIG_HIGH, 8);
      drain();
      hit = 1'b1; tick(); hit = 1'b0; tick();
      push("over_hit_ign", SIG_SCORE, 8);
      drain();

      // Held start in OVER: back to IDLE, no immediate new game
      start_btn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         push("over_hold_state", SIG_STATE, 0);
         drain();
      end
      start_btn = 1'b0; time_left = 6'd40; tick();

      // High-score compare and saturation
      play_game(5);
      play_game(9);
      play_game(260);

      // Reset mid-PLAY abandons the game and clears the high score
      start_btn = 1'b1; tick(); start_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sec_tick = 1'b1; tick(); sec_tick = 1'b0;
      end
      hit = 1'b1; tick(); tick(); tick(); hit = 1'b0;
      push("pre_rst_state", SIG_STATE, 2); push("pre_rst_score", SIG_SCORE, 3);
      drain();
      rst = 1'b1; tick(); rst = 1'b0;
      push("mid_rst_state", SIG_STATE, 0); push("mid_rst_score", SIG_SCORE, 0);
      push("mid_rst_high", SIG_HIGH, 0); push("mid_rst_trst", SIG_TRST, 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
